// File: rtl/product_bcd_converter_pkg.sv
// product_bcd_converter_pkg
//   Shared definitions for the product-to-BCD converter:
//   - FSM state encoding (IDLE, SHIFT, DONE)
//   - iteration-counter width helper, clog2(PROD_W+1)
//   - active-low seven-segment patterns {g,f,e,d,c,b,a}
package product_bcd_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must hold values 0..PROD_W
  function automatic int cnt_width(input int prod_w);
    return $clog2(prod_w + 1);
  endfunction

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/product_bcd_converter_bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational decoder from one BCD digit to an active-low
//   seven-segment pattern {g,f,e,d,c,b,a}. Non-decimal nibbles blank.
// Ports:
//   digit  in  4  BCD digit
//   seg    out 7  active-low segment pattern
module bcd_to_seg7
  import product_bcd_converter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/product_bcd_converter.sv
// product_bcd_converter
//   Captures the multiplier product on the rising edge of `finish` and
//   converts it to packed BCD with a one-bit-per-clock double-dabble
//   engine. The result register only updates on a completed conversion,
//   so the display never shows partial values.
//
//   Optional feature macro: PRODUCT_BCD_SEG_EN
//     defined   -> DIGITS bcd_to_seg7 decoders, registered `seg` output
//     undefined -> `seg` tied to all ones (blank)
//
// Parameters:
//   PROD_W  product width, also the number of shift iterations
//   DIGITS  number of BCD digits (10^DIGITS > 2^PROD_W - 1)
// Ports:
//   clk      in  1          system clock, rising edge
//   reset    in  1          synchronous active-high reset
//   finish   in  1          product-final level from multiplier control
//   product  in  PROD_W     multiplier result
//   bcd      out 4*DIGITS   packed BCD, MS digit in top nibble
//   valid    out 1          bcd holds conversion of current finish period
//   busy     out 1          conversion in progress
//   seg      out 7*DIGITS   active-low segments, digit 0 in low bits
module product_bcd_converter
  import product_bcd_converter_pkg::*;
#(
  parameter int PROD_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  finish,
  input  logic [PROD_W-1:0]     product,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + PROD_W;
  localparam int CNT_W  = cnt_width(PROD_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PROD_W - 1);

  state_t             state_q, state_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [WORK_W-1:0]  work_adj, work_shl;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               finish_q;
  logic               start;

  // Only a rising edge of finish starts a conversion; a held level never
  // retriggers because finish_q follows it one cycle later.
  assign start = finish & ~finish_q;

  // Add-3 correction on every BCD nibble >= 5, ahead of the left shift.
  always_comb begin
    work_adj = work_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_q[PROD_W + 4*d +: 4] >= 4'd5)
        work_adj[PROD_W + 4*d +: 4] = work_q[PROD_W + 4*d +: 4] + 4'd3;
    end
  end

  assign work_shl = {work_adj[WORK_W-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          work_d  = {{BCD_W{1'b0}}, product};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!finish) begin
          // Product withdrawn mid-conversion: abandon, keep old bcd.
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          work_d = work_shl;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            bcd_d   = work_shl[WORK_W-1 -: BCD_W];
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!finish) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      finish_q <= finish;
    end
  end

  // Working shift register is pure data; its contents are reloaded on
  // every start, so it needs no reset.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign busy  = busy_q;

`ifdef PRODUCT_BCD_SEG_EN
  logic [7*DIGITS-1:0] seg_d, seg_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    bcd_to_seg7 u_dec (
      .digit (bcd_q[4*i +: 4]),
      .seg   (seg_d[7*i +: 7])
    );
  end

  // Registered decode: seg trails bcd by one cycle.
  always_ff @(posedge clk) begin
    if (reset) seg_q <= {DIGITS{SEG_0}};
    else       seg_q <= seg_d;
  end

  assign seg = seg_q;
`else
  assign seg = '1;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
module tb_product_bcd_converter;

  localparam int PROD_W = 16;
  localparam int DIGITS = 5;

  logic                 clk;
  logic                 reset;
  logic                 finish;
  logic [PROD_W-1:0]    product;
  logic [4*DIGITS-1:0]  bcd;
  logic                 valid;
  logic                 busy;
  logic [7*DIGITS-1:0]  seg;

  int total = 0;
  int bad   = 0;

  logic [4*DIGITS-1:0] exp_q[$];
  logic                valid_prev = 1'b0;

`ifdef PRODUCT_BCD_SEG_EN
  localparam logic [7*DIGITS-1:0] SEG_RST   = {5{7'h40}};
  localparam logic [7*DIGITS-1:0] SEG_65025 = {7'h02, 7'h12, 7'h40, 7'h24, 7'h12};
`else
  localparam logic [7*DIGITS-1:0] SEG_RST   = '1;
  localparam logic [7*DIGITS-1:0] SEG_65025 = '1;
`endif

  product_bcd_converter #(.PROD_W(PROD_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .finish  (finish),
    .product (product),
    .bcd     (bcd),
    .valid   (valid),
    .busy    (busy),
    .seg     (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of valid must match the next expected result.
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(bcd), 64'hDEAD);
      end else begin
        check("bcd_result", 64'(bcd), 64'(exp_q.pop_front()));
      end
    end
    valid_prev = valid;
  end

  // Raise finish with a product, verify busy/valid timing edge by edge.
  task automatic convert(input logic [PROD_W-1:0] p, input logic [4*DIGITS-1:0] exp);
    @(negedge clk);
    product = p;
    finish  = 1'b1;
    exp_q.push_back(exp);
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e == 1 || e == 8 || e == 16) begin
        check("busy_during", 64'(busy), 64'd1);
        check("valid_during", 64'(valid), 64'd0);
      end
    end
    @(negedge clk);  // after edge 17
    check("valid_done", 64'(valid), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
  endtask

  task automatic drop_finish();
    @(negedge clk);
    finish = 1'b0;
    @(negedge clk);
    check("valid_fall", 64'(valid), 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    finish  = 1'b0;
    product = '0;
    repeat (2) @(negedge clk);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_seg", 64'(seg), 64'(SEG_RST));
    reset = 1'b0;
    @(negedge clk);

    // 12 x 13 = 156
    convert(16'h009C, 20'h00156);
    drop_finish();

    // 255 x 255 = 65025, then seg one cycle after bcd
    convert(16'hFE01, 20'h65025);
    @(negedge clk);
    check("seg_65025", 64'(seg), 64'(SEG_65025));
    drop_finish();

    // zero product, then hold finish for 100 cycles: no retrigger
    convert(16'h0000, 20'h00000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || valid !== 1'b1) begin
        check("hold_busy", 64'(busy), 64'd0);
        check("hold_valid", 64'(valid), 64'd1);
      end
    end
    check("hold_end_valid", 64'(valid), 64'd1);
    check("hold_end_bcd", 64'(bcd), 64'h00000);
    drop_finish();

    // second conversion after finish low
    convert(16'h0064, 20'h00100);
    drop_finish();

    // establish 0x00156, then abort a conversion after edge 8
    convert(16'h009C, 20'h00156);
    drop_finish();
    @(negedge clk);
    product = 16'hFE01;
    finish  = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_busy_pre", 64'(busy), 64'd1);
    finish = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_bcd", 64'(bcd), 64'h00156);
    repeat (3) @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'd0);

    // reset in the middle of a conversion
    @(negedge clk);
    product = 16'h1234;
    finish  = 1'b1;
    repeat (5) @(negedge clk);
    reset  = 1'b1;
    finish = 1'b0;
    @(negedge clk);
    check("midrst_bcd", 64'(bcd), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_seg", 64'(seg), 64'(SEG_RST));

    // normal conversion after reset: 12345
    convert(16'h3039, 20'h12345);
    drop_finish();

    repeat (3) @(negedge clk);
    check("pending_expected", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Downstream consumer of the sequential 8x8 multiplier. Waits for the control unit's `finish` level, captures the 16-bit product and converts it to packed BCD with a sequential shift-add-3 (double dabble) engine, one bit per clock. Presents a stable decimal result with a `valid` flag and, optionally, seven-segment patterns for the board display.

## Interface

Parameters:
- `PROD_W`, 16, product width in bits; also the iteration count.
- `DIGITS`, 5, number of BCD digits; must satisfy 10^DIGITS > 2^PROD_W − 1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `finish`  in  1  level from the multiplier control unit; high while the product is final.
- `product`  in  PROD_W  multiplier result; stable whenever `finish` is high.
- `bcd`  out  4*DIGITS  packed BCD result, most significant digit in the top nibble.
- `valid`  out  1  high while `bcd` holds the conversion of the current `finish` period.
- `busy`  out  1  high during conversion.
- `seg`  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit, digit 0 in the low bits.

## Operation

- One clock; synchronous, active-high reset. On `reset`: state IDLE, `bcd`=0, `valid`=0, `busy`=0, counter=0, `finish_q`=0, `seg` = pattern for all zeros (0x40 per digit with macro; all ones without).
- `finish_q` registers `finish` every cycle. The start condition is `finish & ~finish_q`, a rising edge only. Holding `finish` high never retriggers.
- IDLE: on start, load the work register {4*DIGITS zeros, `product`}, clear the counter, go to SHIFT, `busy`=1.
- SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift the whole work register left 1. Increment the counter. The cycle performing shift number PROD_W writes the BCD field of the result into `bcd`, sets `valid`=1 and `busy`=0, and goes to DONE.
- DONE: hold `bcd` and `valid`. When `finish` is low, clear `valid` and go to IDLE.
- Abort: `finish` low during SHIFT returns to IDLE with `busy`=0 and `valid`=0. `bcd` keeps its previous value.
- `bcd` changes only on conversion completion or reset. The display never shows partial results.
- Simultaneous events: `reset` has priority over everything. A start edge in any state other than IDLE is impossible, because it needs `finish` to have been low, which forces IDLE.

## Timing

- Edge 1 samples the `finish` rise and loads. Edges 2..PROD_W+1 shift. `valid` is high after edge PROD_W+1 (edge 17 for the defaults).
- `valid` falls on the first edge that samples `finish` low.
- `seg` is a registered decode of `bcd`. It lags `bcd` by one cycle.

## Configuration

- `PRODUCT_BCD_SEG_EN` defined: instantiate DIGITS seven-segment decoders. `seg` carries active-low patterns: 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10. Nibbles >9 are blanked (0x7F).
- Not defined: no decoders. `seg` is tied to all ones (blank).

## Structure

- Shared package: state encoding (IDLE, SHIFT, DONE), the iteration-counter width of clog2(PROD_W+1), and the seven-segment pattern constants.
- One sub-module: `bcd_to_seg7`, a 4-bit digit to 7-bit active-low pattern decoder. It is instantiated DIGITS times under the macro.

## Test plan

- `product`=0x009C (12×13=156), `finish` rises → `bcd`=0x00156 and `valid`=1 after edge 17, with `busy` high on edges 2–16.
- `product`=0xFE01 (255×255) → `bcd`=0x65025. `product`=0x0000 → `bcd`=0x00000 and `valid`=1.
- `finish` held high for 100 cycles → exactly one conversion. `finish` low then high again with `product`=0x0064 → second conversion gives `bcd`=0x00100.
- `finish` drops after edge 8 of a conversion → `valid` stays 0, `busy` falls, `bcd` keeps the prior value 0x00156.
- `reset` asserted mid-SHIFT → next edge gives `bcd`=0, `valid`=0, `busy`=0, IDLE. A following `finish` rise converts normally.
- With `PRODUCT_BCD_SEG_EN`, `bcd`=0x65025 → one cycle later `seg` digits 4..0 are 0x02, 0x12, 0x40, 0x24, 0x12. Without the macro, `seg` is all ones.
